lit_formatter: RTL and testbench

- Converts a binary value plus width/base descriptor into a Verilog-style sized-literal ASCII string, e.g. 32'hdead_beef, 8'hff, 32'o377, 32'd255, 1'b1.
- Emits one character per transfer over a valid/ready byte stream.
- Sits on the debug/trace path: simulation readback values are rendered in the same literal syntax the front-end parses, for golden comparison against source literals.

---
 rtl/lit_fmt_pkg.sv | 60 ++++++
 rtl/lit_formatter_if.sv | 26 ++
 rtl/lit_bin2bcd.sv | 71 +++++++
 rtl/lit_formatter.sv | 207 ++++++++++++++++++++
 tb/tb_lit_formatter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lit_fmt_pkg.sv
// Shared types, ASCII constants and small character helpers for the
// sized-literal formatter.
package lit_fmt_pkg;

    typedef enum logic [1:0] {
        BASE_BIN = 2'd0,
        BASE_OCT = 2'd1,
        BASE_DEC = 2'd2,
        BASE_HEX = 2'd3
    } base_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_WID,
        ST_TICK,
        ST_BASE,
        ST_DIG
    } state_e;

    localparam logic [7:0] CH_TICK       = 8'h27;
    localparam logic [7:0] CH_UNDERSCORE = 8'h5f;
    localparam logic [7:0] CH_ZERO       = 8'h30;
    localparam logic [7:0] CH_A_LOWER    = 8'h61;

    localparam int BCD_DIGITS = 10;

    function automatic logic [5:0] clamp_width(input logic [5:0] w);
        return (w == 6'd0 || w > 6'd32) ? 6'd32 : w;
    endfunction

    // tens=1 selects the tens digit of the width, otherwise the ones digit
    function automatic logic [7:0] width_char(input logic [5:0] w, input logic tens);
        logic [5:0] t;
        t = (w >= 6'd30) ? 6'd3 : (w >= 6'd20) ? 6'd2 : (w >= 6'd10) ? 6'd1 : 6'd0;
        return tens ? (CH_ZERO + 8'(t)) : (CH_ZERO + 8'(w - t * 6'd10));
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return (d < 4'd10) ? (CH_ZERO + {4'd0, d}) : (CH_A_LOWER + {4'd0, d} - 8'd10);
    endfunction

    function automatic logic [7:0] base_char(input base_e b);
        case (b)
            BASE_BIN: return 8'h62;
            BASE_OCT: return 8'h6f;
            BASE_DEC: return 8'h64;
            default:  return 8'h68;
        endcase
    endfunction

    function automatic logic [2:0] digit_bits(input base_e b);
        case (b)
            BASE_BIN: return 3'd1;
            BASE_OCT: return 3'd3;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lit_formatter_if.sv
// Request side and character stream of the literal formatter.
// master drives requests and accepts characters; slave is the formatter.
interface lit_formatter_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_value;
    logic [5:0]        in_width;
    logic [1:0]        in_base;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_char;
    logic              out_last;
    logic              busy;

    modport master (
        output in_valid, in_value, in_width, in_base, out_ready,
        input  in_ready, out_valid, out_char, out_last, busy
    );

    modport slave (
        input  in_valid, in_value, in_width, in_base, out_ready,
        output in_ready, out_valid, out_char, out_last, busy
    );
endinterface

// File: rtl/lit_bin2bcd.sv
// Sequential double-dabble: binary to BCD_DIGITS packed BCD digits.
// The first shift happens on the start edge, so done rises DATA_W edges later.
module lit_bin2bcd
    import lit_fmt_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_W-1:0]       value,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int BCD_W = 4 * BCD_DIGITS;

    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic              done_q, done_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = done_q;
        if (start) begin
            // BCD is empty on the first step, so no add-3 pass is needed
            bcd_d  = BCD_W'(value[DATA_W-1]);
            bin_d  = value << 1;
            cnt_d  = CNT_W'(1);
            run_d  = 1'b1;
            done_d = 1'b0;
        end else if (run_q) begin
            bcd_d = (adj << 1) | BCD_W'(bin_q[DATA_W-1]);
            bin_d = bin_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/lit_formatter.sv
// Renders a value as a Verilog sized literal (e.g. 32'hdeadbeef), one char per transfer.
// Define LIT_FMT_UNDERSCORE_EN to group hex/binary digits with '_' every GROUP digits.
module lit_formatter
    import lit_fmt_pkg::*;
#(
    parameter int DATA_W = 32
`ifdef LIT_FMT_UNDERSCORE_EN
    , parameter int GROUP = 4
`endif
) (
    input  logic          clk,
    input  logic          rst,
    lit_formatter_if.slave bus
);
    localparam int SRC_W = 64;
    localparam int BCD_W = 4 * BCD_DIGITS;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [5:0]        width_q, width_d;
    base_e             base_q, base_d;
    logic              wid_hi_q, wid_hi_d;
    logic [4:0]        idx_q, idx_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_char_q, out_char_d;
    logic              out_last_q, out_last_d;
`ifdef LIT_FMT_UNDERSCORE_EN
    logic              us_q, us_d;
`endif

    logic [5:0]        w_in;
    logic [DATA_W-1:0] val_in;
    base_e             base_in;
    logic              xfer;
    logic              bcd_start, bcd_done;
    logic [BCD_W-1:0]  bcd;

    assign w_in    = clamp_width(bus.in_width);
    assign val_in  = bus.in_value & DATA_W'(((DATA_W+1)'(1) << w_in) - (DATA_W+1)'(1));
    assign base_in = base_e'(bus.in_base);
    assign xfer    = out_valid_q && bus.out_ready;

    lit_bin2bcd #(.DATA_W(DATA_W)) u_bcd (
        .clk  (clk),
        .rst  (rst),
        .start(bcd_start),
        .value(val_in),
        .done (bcd_done),
        .bcd  (bcd)
    );

    // Digit k of the latched value in the latched base, plus the most
    // significant non-zero digit index (0 when the value is zero).
    logic [31:0][3:0] digs;
    logic [4:0]       msd;
    logic [SRC_W-1:0] src;
    logic [2:0]       bpd;
    logic [3:0]       dmask;

    always_comb begin
        src   = (base_q == BASE_DEC) ? SRC_W'(bcd) : SRC_W'(val_q);
        bpd   = digit_bits(base_q);
        dmask = 4'((5'd1 << bpd) - 5'd1);
        msd   = '0;
        digs  = '0;
        for (int i = 0; i < 32; i++) begin
            digs[i] = 4'(src >> (i * int'(bpd))) & dmask;
            if (digs[i] != 4'd0) msd = 5'(i);
        end
    end

    // out_*_q always hold the character currently offered; each branch loads
    // the following character on the transfer that retires the current one.
    always_comb begin
        state_d     = state_q;
        val_d       = val_q;
        width_d     = width_q;
        base_d      = base_q;
        wid_hi_d    = wid_hi_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_char_d  = out_char_q;
        out_last_d  = out_last_q;
        bcd_start   = 1'b0;
`ifdef LIT_FMT_UNDERSCORE_EN
        us_d        = us_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    val_d   = val_in;
                    width_d = w_in;
                    base_d  = base_in;
                    if (base_in == BASE_DEC) begin
                        state_d   = ST_CONV;
                        bcd_start = 1'b1;
                    end else begin
                        state_d     = ST_WID;
                        out_valid_d = 1'b1;
                        out_char_d  = width_char(w_in, w_in >= 6'd10);
                        wid_hi_d    = (w_in >= 6'd10);
                    end
                end
            end
            ST_CONV: begin
                if (bcd_done) begin
                    state_d     = ST_WID;
                    out_valid_d = 1'b1;
                    out_char_d  = width_char(width_q, width_q >= 6'd10);
                    wid_hi_d    = (width_q >= 6'd10);
                end
            end
            ST_WID: begin
                if (xfer) begin
                    if (wid_hi_q) begin
                        wid_hi_d   = 1'b0;
                        out_char_d = width_char(width_q, 1'b0);
                    end else begin
                        state_d    = ST_TICK;
                        out_char_d = CH_TICK;
                    end
                end
            end
            ST_TICK: begin
                if (xfer) begin
                    state_d    = ST_BASE;
                    out_char_d = base_char(base_q);
                end
            end
            ST_BASE: begin
                if (xfer) begin
                    state_d    = ST_DIG;
                    idx_d      = msd;
                    out_char_d = digit_char(digs[msd]);
                    out_last_d = (msd == 5'd0);
`ifdef LIT_FMT_UNDERSCORE_EN
                    us_d       = 1'b0;
`endif
                end
            end
            ST_DIG: begin
                if (xfer) begin
                    if (out_last_q) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_char_d  = 8'h00;
                    end
`ifdef LIT_FMT_UNDERSCORE_EN
                    // idx_q > 0 here, so the separator is never trailing
                    else if (!us_q && (base_q == BASE_HEX || base_q == BASE_BIN) &&
                             (int'(idx_q) % GROUP) == 0) begin
                        us_d       = 1'b1;
                        out_char_d = CH_UNDERSCORE;
                    end
`endif
                    else begin
                        idx_d      = idx_q - 5'd1;
                        out_char_d = digit_char(digs[idx_q - 5'd1]);
                        out_last_d = (idx_q == 5'd1);
`ifdef LIT_FMT_UNDERSCORE_EN
                        us_d       = 1'b0;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            val_q       <= '0;
            width_q     <= '0;
            base_q      <= BASE_BIN;
            wid_hi_q    <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
            out_last_q  <= 1'b0;
`ifdef LIT_FMT_UNDERSCORE_EN
            us_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            val_q       <= val_d;
            width_q     <= width_d;
            base_q      <= base_d;
            wid_hi_q    <= wid_hi_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            out_last_q  <= out_last_d;
`ifdef LIT_FMT_UNDERSCORE_EN
            us_q        <= us_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_char  = out_char_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_lit_formatter.sv
// Scoreboard bench for lit_formatter: expected strings queued at acceptance,
// an independent monitor pops and compares every transferred character.
module tb_lit_formatter;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lit_formatter_if #(.DATA_W(DATA_W)) bus ();
    lit_formatter #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [8:0] exp_q[$];
    bit   rnd_ready = 0;
    bit   wait_first = 0;
    int   acc_cyc = 0;
    int   exp_lat = 0;
    int   last_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: repeated division by the radix, independent of digit-slicing hardware
    function automatic string model(input logic [31:0] v, input logic [5:0] win, input logic [1:0] b);
        int w, radix, n, d;
        longint unsigned m;
        string digs, bc, hexd;
        hexd = "0123456789abcdef";
        w = (win == 0 || win > 32) ? 32 : int'(win);
        m = 64'(v) & ((64'd1 << w) - 64'd1);
        case (b)
            2'd0: begin radix = 2;  bc = "b"; end
            2'd1: begin radix = 8;  bc = "o"; end
            2'd2: begin radix = 10; bc = "d"; end
            default: begin radix = 16; bc = "h"; end
        endcase
        digs = "";
        n = 0;
        do begin
`ifdef LIT_FMT_UNDERSCORE_EN
            if ((radix == 2 || radix == 16) && n > 0 && n % 4 == 0) digs = {"_", digs};
`endif
            d = int'(m % 64'(radix));
            digs = {hexd.substr(d, d), digs};
            m = m / 64'(radix);
            n++;
        end while (m != 0);
        return $sformatf("%0d'%s%s", w, bc, digs);
    endfunction

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rnd_ready ? ($urandom_range(0, 99) < 55) : 1'b1;
        end
    end

    // Monitor: transfers, stall stability, first-char latency, no bubbles
    initial begin
        logic [8:0] e;
        bit   held_v, in_str;
        logic [7:0] held_c;
        logic held_l;
        held_v = 0; in_str = 0; held_c = '0; held_l = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 0;
                in_str = 0;
            end else begin
                if (held_v) check("stall_hold", {bus.out_valid, bus.out_last, bus.out_char}, {1'b1, held_l, held_c});
                check("ready_vs_busy", bus.in_ready, !bus.busy);
                if (wait_first && bus.out_valid) begin
                    check("first_latency", cyc - acc_cyc, exp_lat);
                    wait_first = 0;
                end
                if (!rnd_ready && in_str) check("no_bubble", bus.out_valid, 1'b1);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_char", {bus.out_last, bus.out_char}, 9'h1ff);
                    end else begin
                        e = exp_q.pop_front();
                        check("char", {bus.out_last, bus.out_char}, e);
                    end
                    if (bus.out_last) begin
                        last_cyc = cyc;
                        in_str = 0;
                    end else begin
                        in_str = 1;
                    end
                end
                held_v = bus.out_valid && !bus.out_ready;
                held_c = bus.out_char;
                held_l = bus.out_last;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] v, input logic [5:0] w, input logic [1:0] b, input string s);
        int n;
        bit waited;
        bus.in_valid = 1'b1;
        bus.in_value = v;
        bus.in_width = w;
        bus.in_base  = b;
        waited = 0;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 3000) begin
            waited = 1;
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            if (waited) check("b2b_accept_cycle", cyc, last_cyc + 1);
            for (int i = 0; i < s.len(); i++) exp_q.push_back({(i == s.len() - 1), 8'(s[i])});
            acc_cyc    = cyc;
            exp_lat    = (b == 2'd2) ? DATA_W + 1 : 1;
            wait_first = 1;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_value = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", bus.busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [31:0] v;
        logic [5:0]  w;
        logic [1:0]  b;
        string s;
        int n, len0;
        bus.in_valid = 1'b0;
        bus.in_value = '0;
        bus.in_width = '0;
        bus.in_base  = '0;
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_char", bus.out_char, 8'h00);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

`ifdef LIT_FMT_UNDERSCORE_EN
        send(32'hDEADBEEF, 6'd32, 2'd3, "32'hdead_beef");
        send(32'h00010000, 6'd32, 2'd3, "32'h1_0000");
        send(32'h0000001F, 6'd12, 2'd0, "12'b1_1111");
`else
        send(32'hDEADBEEF, 6'd32, 2'd3, "32'hdeadbeef");
        send(32'h00010000, 6'd32, 2'd3, "32'h10000");
        send(32'h0000001F, 6'd12, 2'd0, "12'b11111");
`endif
        send(32'h1, 6'd1, 2'd0, "1'b1");
        send(32'h1FF, 6'd8, 2'd3, "8'hff");
        send(32'h0, 6'd32, 2'd3, "32'h0");
        send(32'd255, 6'd32, 2'd1, "32'o377");
        send(32'd255, 6'd32, 2'd2, "32'd255");
        send(32'hFFFFFFFF, 6'd32, 2'd2, "32'd4294967295");
        send(32'h5, 6'd0, 2'd0, "32'b101");
        send(32'hA, 6'd40, 2'd3, "32'ha");
        send(32'h3FF, 6'd10, 2'd1, "10'o1777");
        drain();

        rnd_ready = 1;
        for (int k = 0; k < 40; k++) begin
            v = $urandom;
            if ($urandom_range(0, 3) == 0) v = v & 32'h0000_00FF;
            w = 6'($urandom_range(0, 40));
            b = 2'($urandom_range(0, 3));
            send(v, w, b, model(v, w, b));
        end
        drain();

        // Reset in the middle of the digit phase
        rnd_ready = 0;
        s = model(32'hF0F0F0F0, 6'd32, 2'd0);
        len0 = s.len();
        send(32'hF0F0F0F0, 6'd32, 2'd0, s);
        n = 0;
        while (exp_q.size() > len0 - 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_dig", exp_q.size() <= len0 - 10, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_out_last", bus.out_last, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_in_ready", bus.in_ready, 1'b1);
        exp_q.delete();
        wait_first = 0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("postrst_idle_valid", bus.out_valid, 1'b0);
        check("postrst_idle_busy", bus.busy, 1'b0);
        @(posedge clk);
        #1;
        send(32'h0000BEEF, 6'd16, 2'd3, model(32'h0000BEEF, 6'd16, 2'd3));
        send(32'd1234, 6'd11, 2'd2, model(32'd1234, 6'd11, 2'd2));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
